rgmii_idelay_tuner: RTL
=======================

Name: rgmii_idelay_tuner

Overview:
- Runtime controller for the RGMII receive IDELAYE2 chain, replacing fixed-tap delays.
- Drives the IDELAYE2 instances in VAR_LOAD mode: one clock lane plus LANES-1 data/ctl lanes.
- Accepts per-lane tap writes from software.
- Runs an automatic sweep that counts good/bad received frames per data tap, then loads the centre of the widest passing window.
- Sits beside the 1G RGMII MAC and shares its 125 MHz logic clock; the IDELAYE2 C pins take the same clock.

Parameters:
LANES, 6, total delay lanes; lane 0 = rx clock, lanes 1..LANES-1 = rxd[3:0] + rx_ctl
TAP_W, 5, tap width (IDELAYE2 CNTVALUE)
CLK_TAP_INIT, 0, reset tap for lane 0
DATA_TAP_INIT, 16, reset tap for lanes 1..LANES-1
FRAMES_PER_TAP, 16, frames judged per sweep step
SETTLE_CYCLES, 64, wait after each tap load before counting
TIMEOUT_CYCLES, 1000000, max measure time per tap

Ports:
clock  in  1  logic clock, 125 MHz
resetn  in  1  asynchronous active-low reset
idelayctrl_rdy  in  1  IDELAYCTRL RDY, synchronised internally (2 flops)
cfg_valid  in  1  tap write request
cfg_ready  out  1  write accepted when valid&ready
cfg_lane  in  $clog2(LANES)  target lane
cfg_tap  in  TAP_W  tap value
sweep_start  in  1  single-cycle pulse, start data-lane sweep
frame_good  in  1  single-cycle pulse per good rx frame (from MAC)
frame_bad  in  1  single-cycle pulse per bad-FCS/errored rx frame
idelay_ld  out  LANES  per-lane LD to IDELAYE2
idelay_cntvalue  out  LANES*TAP_W  per-lane CNTVALUEIN, lane n at [n*TAP_W +: TAP_W]
sweep_busy  out  1  sweep in progress
sweep_done  out  1  one-cycle pulse at sweep end
sweep_fail  out  1  sticky: last sweep found no passing tap; cleared at next sweep_start
win_start  out  TAP_W  first tap of best window
win_len  out  TAP_W+1  length of best window (0..2^TAP_W)

Behaviour:
- Reset values: idelay_cntvalue = CLK_TAP_INIT on lane 0, DATA_TAP_INIT on others. idelay_ld=0, cfg_ready=0, sweep_busy=0, sweep_done=0, sweep_fail=0, win_start=0, win_len=0. State WAIT_RDY.
- LD protocol: cntvalue and ld change on the same edge. ld high exactly one cycle. cntvalue holds afterwards.
- WAIT_RDY: all outputs hold. When synchronised rdy=1, go to LOAD_ALL.
- LOAD_ALL: one cycle with all ld bits set, current tap registers driven. Then IDLE.
- IDLE:
  - cfg_ready=1.
  - On handshake: go to LOAD, update the target lane tap. Next cycle, only ld[cfg_lane]=1, then IDLE. cfg_ready=0 during LOAD.
  - cfg_lane >= LANES: accepted, no effect.
  - Simultaneous cfg handshake and sweep_start: cfg wins; sweep_start is dropped.
- Sweep:
  - sweep_start in IDLE: sweep_busy=1, sweep_fail=0, tap=0, best=(0,0), run=0. Previous data tap is saved.
  - SET: load tap into all data lanes (ld pulse).
  - SETTLE: count SETTLE_CYCLES; frame pulses ignored.
  - MEASURE: count good and bad pulses (both may assert in one cycle; each counted). Ends when good+bad >= FRAMES_PER_TAP or TIMEOUT_CYCLES elapse.
  - Pass = (bad==0 && good>=FRAMES_PER_TAP). Timeout = fail.
  - On pass: run++. On fail: close the run.
  - A run replaces best only if strictly longer (ties keep the lower window).
  - After tap 2^TAP_W-1, close any open run, go to FINISH. No wrap-around.
- FINISH:
  - win_len>0: load data lanes with win_start + (win_len-1)/2 (floor, TAP_W-bit).
  - win_len==0: sweep_fail=1, reload the saved previous tap.
  - Then sweep_done pulse, sweep_busy=0, go to IDLE. Lane 0 is never changed by a sweep.
- sweep_start while busy: ignored. cfg_ready=0 while busy.
- Synchronised rdy drops in any state:
  - Go to WAIT_RDY; busy=0, no done pulse, sweep results unchanged.
  - Tap registers keep their current values; LOAD_ALL reapplies them on recovery.
- Counters saturate; no wrap.

Test Plan:
- Reset then rdy=1 after 10 cycles → after the 2-flop sync, one cycle all ld=6'b111111; cntvalue lane0=0, lanes1-5=16.
- cfg write lane 3 tap 9 → cfg_ready drops 1 cycle, next cycle ld=6'b001000, lane3=9, others unchanged.
- Sweep with model: good frames for taps 10..20, bad frames elsewhere → win_start=10, win_len=11, data lanes=15, done pulse, fail=0, lane0 untouched.
- Sweep with two windows 3..6 and 20..23 (equal length 4) → win_start=3, final tap=4.
- Sweep with all taps bad, previous tap 16 → sweep_fail=1, data lanes reloaded to 16; with no frames at all, each tap times out, same result.
- rdy dropped mid-MEASURE at tap 7 → busy=0, no done, taps held; rdy restored → LOAD_ALL reloads tap 7 on data lanes.

Source files
------------

// File: rtl/rgmii_idelay_tuner.sv
// rgmii_idelay_tuner: runtime IDELAYE2 tap controller with software writes and automatic data-lane sweep
module rgmii_idelay_tuner #(
    parameter int LANES          = 6,
    parameter int TAP_W          = 5,
    parameter int CLK_TAP_INIT   = 0,
    parameter int DATA_TAP_INIT  = 16,
    parameter int FRAMES_PER_TAP = 16,
    parameter int SETTLE_CYCLES  = 64,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     idelayctrl_rdy,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [$clog2(LANES)-1:0] cfg_lane,
    input  logic [TAP_W-1:0]         cfg_tap,
    input  logic                     sweep_start,
    input  logic                     frame_good,
    input  logic                     frame_bad,
    output logic [LANES-1:0]         idelay_ld,
    output logic [LANES*TAP_W-1:0]   idelay_cntvalue,
    output logic                     sweep_busy,
    output logic                     sweep_done,
    output logic                     sweep_fail,
    output logic [TAP_W-1:0]         win_start,
    output logic [TAP_W:0]           win_len
);
    localparam int CMAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(CMAX + 1);
    localparam int FW = $clog2(FRAMES_PER_TAP + 1) + 1;
    localparam logic [LANES-1:0] DMASK = {{(LANES-1){1'b1}}, 1'b0};
    localparam logic [TAP_W-1:0] TMAX = '1;

    function automatic logic [LANES*TAP_W-1:0] init_taps();
        logic [LANES*TAP_W-1:0] v;
        for (int i = 0; i < LANES; i++)
            v[i*TAP_W +: TAP_W] = (i == 0) ? TAP_W'(CLK_TAP_INIT) : TAP_W'(DATA_TAP_INIT);
        return v;
    endfunction

    localparam logic [LANES*TAP_W-1:0] TAP_RST = init_taps();

    // all data lanes set to t, lane 0 kept
    function automatic logic [LANES*TAP_W-1:0] fill(input logic [TAP_W-1:0] t, input logic [TAP_W-1:0] l0);
        return {{(LANES-1){t}}, l0};
    endfunction

    typedef enum logic [3:0] {
        WAIT_RDY, LOAD_ALL, IDLE, LOAD, SW_SET, SW_SETTLE, SW_MEAS, SW_FINISH, SW_DONE
    } state_t;

    state_t                   state, state_n;
    logic                     rdy_m, rdy_s;
    logic [LANES-1:0]         ld_n;
    logic [LANES*TAP_W-1:0]   taps_q, taps_n, save_q, save_n;
    logic [TAP_W-1:0]         tap_q, tap_n, bs_q, bs_n, ws_n;
    logic [TAP_W:0]           run_q, run_n, bl_q, bl_n, wl_n, run_inc;
    logic [CW-1:0]            cnt_q, cnt_n;
    logic [FW-1:0]            good_q, good_n, bad_q, bad_n, g_inc, b_inc;
    logic                     fail_n, m_end, pass;

    assign idelay_cntvalue = taps_q;
    assign cfg_ready       = (state == IDLE) && rdy_s;
    assign sweep_busy      = (state == SW_SET) || (state == SW_SETTLE) || (state == SW_MEAS) || (state == SW_FINISH);
    assign sweep_done      = (state == SW_DONE);

    // two-flop synchroniser for IDELAYCTRL ready
    always_ff @(posedge clock or negedge resetn)
        if (!resetn) {rdy_s, rdy_m} <= 2'b00;
        else {rdy_s, rdy_m} <= {rdy_m, idelayctrl_rdy};

    // state register
    always_ff @(posedge clock or negedge resetn)
        if (!resetn) state <= WAIT_RDY;
        else state <= state_n;

    // next state, tap loads and sweep bookkeeping
    always_comb begin
        state_n = state;
        ld_n    = '0;
        taps_n  = taps_q;
        save_n  = save_q;
        tap_n   = tap_q;
        cnt_n   = cnt_q;
        good_n  = good_q;
        bad_n   = bad_q;
        run_n   = run_q;
        bs_n    = bs_q;
        bl_n    = bl_q;
        ws_n    = win_start;
        wl_n    = win_len;
        fail_n  = sweep_fail;
        g_inc   = good_q + FW'(frame_good && !(&good_q));
        b_inc   = bad_q + FW'(frame_bad && !(&bad_q));
        m_end   = ((FW+1)'(g_inc) + (FW+1)'(b_inc) >= (FW+1)'(FRAMES_PER_TAP)) || (cnt_q >= CW'(TIMEOUT_CYCLES - 1));
        pass    = (b_inc == '0) && (g_inc >= FW'(FRAMES_PER_TAP));
        run_inc = run_q + 1'b1;
        if (!rdy_s) state_n = WAIT_RDY;
        else case (state)
            WAIT_RDY: begin
                state_n = LOAD_ALL;
                ld_n    = '1;
            end
            LOAD_ALL, LOAD, SW_DONE: state_n = IDLE;
            IDLE: begin
                if (cfg_valid) begin
                    state_n = LOAD;
                    if (int'(cfg_lane) < LANES) begin
                        taps_n[int'(cfg_lane)*TAP_W +: TAP_W] = cfg_tap;
                        ld_n[cfg_lane] = 1'b1;
                    end
                end else if (sweep_start) begin
                    state_n = SW_SET;
                    fail_n  = 1'b0;
                    tap_n   = '0;
                    bs_n    = '0;
                    bl_n    = '0;
                    run_n   = '0;
                    save_n  = taps_q;
                    taps_n  = fill('0, taps_q[TAP_W-1:0]);
                    ld_n    = DMASK;
                end
            end
            SW_SET: begin
                state_n = SW_SETTLE;
                cnt_n   = '0;
            end
            SW_SETTLE: begin
                if (cnt_q >= CW'(SETTLE_CYCLES - 1)) begin
                    state_n = SW_MEAS;
                    cnt_n   = '0;
                    good_n  = '0;
                    bad_n   = '0;
                end else cnt_n = cnt_q + 1'b1;
            end
            SW_MEAS: begin
                good_n = g_inc;
                bad_n  = b_inc;
                cnt_n  = cnt_q + CW'(!(&cnt_q));
                if (m_end) begin
                    run_n = pass ? run_inc : '0;
                    if (pass && run_inc > bl_q) begin
                        bl_n = run_inc;
                        bs_n = tap_q - TAP_W'(run_q);
                    end
                    if (tap_q == TMAX) state_n = SW_FINISH;
                    else begin
                        state_n = SW_SET;
                        tap_n   = tap_q + 1'b1;
                        taps_n  = fill(tap_q + 1'b1, taps_q[TAP_W-1:0]);
                        ld_n    = DMASK;
                    end
                end
            end
            SW_FINISH: begin
                state_n = SW_DONE;
                ws_n    = bs_q;
                wl_n    = bl_q;
                ld_n    = DMASK;
                if (bl_q != '0) taps_n = fill(bs_q + TAP_W'((bl_q - 1'b1) >> 1), taps_q[TAP_W-1:0]);
                else begin
                    fail_n = 1'b1;
                    taps_n = {save_q[LANES*TAP_W-1:TAP_W], taps_q[TAP_W-1:0]};
                end
            end
            default: state_n = WAIT_RDY;
        endcase
    end

    // registered datapath: ld and cntvalue move on the same edge
    always_ff @(posedge clock or negedge resetn)
        if (!resetn) begin
            idelay_ld  <= '0;
            taps_q     <= TAP_RST;
            save_q     <= TAP_RST;
            tap_q      <= '0;
            cnt_q      <= '0;
            good_q     <= '0;
            bad_q      <= '0;
            run_q      <= '0;
            bs_q       <= '0;
            bl_q       <= '0;
            win_start  <= '0;
            win_len    <= '0;
            sweep_fail <= 1'b0;
        end else begin
            idelay_ld  <= ld_n;
            taps_q     <= taps_n;
            save_q     <= save_n;
            tap_q      <= tap_n;
            cnt_q      <= cnt_n;
            good_q     <= good_n;
            bad_q      <= bad_n;
            run_q      <= run_n;
            bs_q       <= bs_n;
            bl_q       <= bl_n;
            win_start  <= ws_n;
            win_len    <= wl_n;
            sweep_fail <= fail_n;
        end
endmodule
